// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned DEF_IDW       = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or above start, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // explicit modulo so non-power-of-two N wraps correctly
            cand = IW'((32'(start) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers in bounded bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned IDW       = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] din,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [DW-1:0]         fifo_d,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [IDW-1:0]        owner,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    state_t        state;
    logic [IDW-1:0] last_owner;
    logic [CW-1:0]  burst_cnt;
    logic [IDW-1:0] start;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic           accept;

    // search begins one past the previous owner so every requester gets a turn
    assign start = (last_owner == IDW'(NUM_REQ - 1)) ? '0 : last_owner + IDW'(1);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req   (req),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign accept = (state == BURST) && req[owner] && !fifo_full;
    assign busy   = (state == BURST);

    always_comb begin
        fifo_wen = accept;
        fifo_d   = '0;
        gnt      = '0;
        if (accept) begin
            fifo_d     = din[32'(owner) * DW +: DW];
            gnt[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end else if (!fifo_full) begin
                        burst_cnt <= burst_cnt + CW'(1);
                        if (burst_cnt == CW'(MAX_BURST - 1)) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a burst-level behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        fifo_full;
    logic        fifo_wen;
    logic [7:0]  fifo_d;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int passes = 0;

    // producers: words still to send and the word currently on each lane
    int         rem [NR];
    logic [7:0] word [NR];
    bit         full_force;
    bit         fill_mode;
    logic [7:0] fq [$];
    logic [7:0] xq [$];

    // model: burst owner and words still allowed in the current burst
    bit m_busy;
    int m_owner;
    int m_last;
    int m_left;

    logic [15:0] obs;
    logic [15:0] expv;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DW        (8),
        .MAX_BURST (4),
        .IDW       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_d    (fifo_d),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic drive_cycle(input bit r);
        bit         e_wen;
        logic [3:0] e_gnt;
        logic [7:0] e_d;
        bit         found;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < NR; i++) begin
            req[i]         = (rem[i] > 0);
            din[i*8 +: 8]  = word[i];
        end
        fifo_full = full_force || (fill_mode && fq.size() >= 32);
        #1;
        e_wen = m_busy && req[m_owner] && !fifo_full;
        e_gnt = e_wen ? 4'(1 << m_owner) : 4'd0;
        e_d   = e_wen ? word[m_owner] : 8'd0;
        expv  = {m_busy, e_wen, e_gnt, e_d, m_busy ? 2'(m_owner) : 2'd0};
        obs   = {busy, fifo_wen, gnt, fifo_d, busy ? owner : 2'd0};
        if (fill_mode && fifo_wen && fq.size() < 32) fq.push_back(fifo_d);
        if (fill_mode && e_wen) xq.push_back(e_d);
        if (e_wen) begin
            rem[m_owner]--;
            word[m_owner] = word[m_owner] + 8'd1;
        end
        if (r) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NR - 1;
            m_left  = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (!found && req[c]) begin
                    found   = 1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_busy = 1;
                m_left = MB;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end else if (!fifo_full) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
    endtask

    task automatic reset_all();
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 0;
            word[i] = 8'd0;
        end
        full_force = 0;
        fill_mode  = 0;
        drive_cycle(1);
        drive_cycle(1);
    endtask

    task automatic test_reset();
        reset_all();
        drive_cycle(0);
        checks++;
        if (obs !== 16'h0000) $display("FAIL reset_outputs obs=%h exp=%h", obs, 16'h0000);
        else passes++;
        checks++;
        if (obs !== expv) $display("FAIL reset_model obs=%h exp=%h", obs, expv);
        else passes++;
    endtask

    task automatic test_single();
        int n_w = 0;
        reset_all();
        rem[2]  = 8;
        word[2] = 8'hA0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(0);
            checks++;
            if (obs !== expv) $display("FAIL single cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
            if (fifo_wen) begin
                checks++;
                if (fifo_d !== 8'(8'hA0 + n_w) || gnt !== 4'b0100)
                    $display("FAIL single_data w%0d d=%h gnt=%b exp d=%h gnt=0100", n_w, fifo_d, gnt, 8'(8'hA0 + n_w));
                else passes++;
                n_w++;
            end
        end
        checks++;
        if (n_w !== 8) $display("FAIL single_count got=%0d exp=8", n_w);
        else passes++;
    endtask

    task automatic test_all_req();
        int wo [$];
        int ord [5] = '{0, 1, 2, 3, 0};
        reset_all();
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 8;
            word[i] = 8'(i * 16);
        end
        for (int i = 0; i < 26; i++) begin
            drive_cycle(0);
            checks++;
            if (obs !== expv) $display("FAIL all_req cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
            if (fifo_wen) wo.push_back(int'(owner));
        end
        checks++;
        if (wo.size() < 20) $display("FAIL all_req_writes got=%0d exp>=20", wo.size());
        else begin
            passes++;
            for (int k = 0; k < 20; k++) begin
                checks++;
                if (wo[k] != ord[k/4]) $display("FAIL all_req_order w%0d owner=%0d exp=%0d", k, wo[k], ord[k/4]);
                else passes++;
            end
        end
    endtask

    task automatic test_full_mid();
        int stall = 0;
        int nwr   = 0;
        reset_all();
        rem[1]  = 4;
        word[1] = 8'h10;
        for (int i = 0; i < 12; i++) begin
            full_force = (i >= 3 && i < 8);
            drive_cycle(0);
            checks++;
            if (obs !== expv) $display("FAIL full_mid cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
            if (full_force && busy && !fifo_wen) stall++;
            if (fifo_wen) nwr++;
        end
        full_force = 0;
        checks++;
        if (stall !== 5) $display("FAIL full_mid_stall got=%0d exp=5", stall);
        else passes++;
        checks++;
        if (nwr !== 4) $display("FAIL full_mid_writes got=%0d exp=4", nwr);
        else passes++;
    endtask

    task automatic test_early();
        bit seen = 0;
        reset_all();
        rem[3]  = 1;
        word[3] = 8'h30;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                rem[0]  = 2;
                word[0] = 8'h05;
            end
            drive_cycle(0);
            checks++;
            if (obs !== expv) $display("FAIL early cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
            if (i == 3) begin
                checks++;
                if (busy !== 1'b0) $display("FAIL early_idle busy=%b exp=0", busy);
                else passes++;
            end
            if (i >= 2 && fifo_wen && !seen) begin
                seen = 1;
                checks++;
                if (owner !== 2'd0 || fifo_d !== 8'h05)
                    $display("FAIL early_wrap owner=%0d d=%h exp owner=0 d=05", owner, fifo_d);
                else passes++;
            end
        end
        checks++;
        if (!seen) $display("FAIL early_nowrite seen=0 exp=1");
        else passes++;
    endtask

    task automatic test_reset_mid();
        reset_all();
        rem[2]  = 4;
        word[2] = 8'h20;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                rem[0]  = 2;
                word[0] = 8'h50;
            end
            drive_cycle(i == 2);
            checks++;
            if (obs !== expv) $display("FAIL reset_mid cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
            if (i == 3) begin
                checks++;
                if ({busy, fifo_wen, gnt} !== 6'b0)
                    $display("FAIL reset_mid_idle busy=%b wen=%b gnt=%b exp 0/0/0000", busy, fifo_wen, gnt);
                else passes++;
            end
            if (i == 4) begin
                checks++;
                if (gnt !== 4'b0001 || fifo_d !== 8'h50)
                    $display("FAIL reset_mid_regrant gnt=%b d=%h exp gnt=0001 d=50", gnt, fifo_d);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        reset_all();
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < NR; l++) begin
                if (rem[l] == 0 && $urandom_range(0, 9) < 3) begin
                    rem[l]  = int'($urandom_range(1, 6));
                    word[l] = 8'($urandom);
                end
            end
            full_force = ($urandom_range(0, 4) == 0);
            drive_cycle(0);
            checks++;
            if (obs !== expv) $display("FAIL random cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
        end
        full_force = 0;
    endtask

    task automatic test_fill();
        int bad = 0;
        reset_all();
        fill_mode = 1;
        fq.delete();
        xq.delete();
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 12;
            word[i] = 8'(i * 64);
        end
        for (int i = 0; i < 70; i++) begin
            drive_cycle(0);
            checks++;
            if (obs !== expv) $display("FAIL fill cyc%0d obs=%h exp=%h", i, obs, expv);
            else passes++;
            if (fifo_full && fifo_wen) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL fill_write_when_full got=%0d exp=0", bad);
        else passes++;
        checks++;
        if (fq.size() !== 32 || xq.size() !== 32)
            $display("FAIL fill_depth got=%0d model=%0d exp=32", fq.size(), xq.size());
        else begin
            passes++;
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (fq[k] !== xq[k]) $display("FAIL fill_order e%0d got=%h exp=%h", k, fq[k], xq[k]);
                else passes++;
            end
        end
        fill_mode = 0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        din        = '0;
        fifo_full  = 1'b0;
        m_busy     = 0;
        m_owner    = 0;
        m_last     = NR - 1;
        m_left     = 0;
        test_reset();
        test_single();
        test_all_req();
        test_full_mid();
        test_early();
        test_reset_mid();
        test_random();
        test_fill();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
